// File: rtl/br_pkg.sv
// Shared types for the branch resolution unit: operation encoding and the S1 pipeline record.
package br_pkg;

    localparam int OP_W    = 4;
    localparam int BR_XLEN = 32;

    typedef enum logic [OP_W-1:0] {
        BEQ  = 4'd0,
        BNE  = 4'd1,
        BLT  = 4'd2,
        BGE  = 4'd3,
        BLTU = 4'd4,
        BGEU = 4'd5,
        JAL  = 4'd6,
        JALR = 4'd7
    } br_op_e;

    // State carried from S1 to S2; the fall-through PC is precomputed so S2 only selects.
    typedef struct packed {
        logic               taken;
        logic [BR_XLEN-1:0] target;
        logic [BR_XLEN-1:0] fallthru;
        logic               pred_taken;
        logic [BR_XLEN-1:0] pred_target;
    } br_s1_t;

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Request/response handshake bundle between the EX issue side and the branch resolution unit.
interface branch_resolve_unit_if #(
    parameter int XLEN = 32,
    parameter int OP_W = 4
);
    logic            in_valid;
    logic            in_ready;
    logic [OP_W-1:0] in_op;
    logic [XLEN-1:0] in_a;
    logic [XLEN-1:0] in_b;
    logic [XLEN-1:0] in_pc;
    logic [XLEN-1:0] in_imm;
    logic            in_pred_taken;
    logic [XLEN-1:0] in_pred_target;
    logic            out_valid;
    logic            out_ready;
    logic            out_taken;
    logic [XLEN-1:0] out_target;
    logic [XLEN-1:0] out_next_pc;
    logic            out_mispredict;

    modport master (
        output in_valid, in_op, in_a, in_b, in_pc, in_imm, in_pred_taken, in_pred_target,
        output out_ready,
        input  in_ready, out_valid, out_taken, out_target, out_next_pc, out_mispredict
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, in_pc, in_imm, in_pred_taken, in_pred_target,
        input  out_ready,
        output in_ready, out_valid, out_taken, out_target, out_next_pc, out_mispredict
    );
endinterface

// File: rtl/branch_cond_core.sv
// Combinational branch condition evaluation; unknown encodings resolve as not taken.
module branch_cond_core
    import br_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [OP_W-1:0] op,
    output logic            taken
);

    // Condition select by operation
    always_comb begin
        taken = 1'b0;
        case (op)
            BEQ:       taken = (a == b);
            BNE:       taken = (a != b);
            BLT:       taken = ($signed(a) <  $signed(b));
            BGE:       taken = ($signed(a) >= $signed(b));
            BLTU:      taken = (a <  b);
            BGEU:      taken = (a >= b);
            JAL, JALR: taken = 1'b1;
            default:   taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Two-stage branch resolution: S1 evaluates condition/target, S2 registers redirect result.
// Optional BRANCH_STATS_EN adds resolved-branch and mispredict counters.
module branch_resolve_unit
#(
    parameter int XLEN   = br_pkg::BR_XLEN,
    parameter int OP_W   = br_pkg::OP_W,
    parameter int ILEN_B = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    branch_resolve_unit_if.slave  bus
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0]           stat_branches,
    output logic [31:0]           stat_mispred
`endif
);
    import br_pkg::*;

    logic            s1_valid_r;
    br_s1_t          s1_r;
    logic            s2_valid_r;
    logic            out_taken_r;
    logic            out_mispredict_r;
    logic [XLEN-1:0] out_target_r;
    logic [XLEN-1:0] out_next_pc_r;

    logic            cond_taken_s;
    logic [XLEN-1:0] sum_s;
    logic [XLEN-1:0] target_s;
    logic [XLEN-1:0] fallthru_s;
    logic            s2_move_s;
    logic            in_ready_s;
    logic            out_valid_s;
    logic            out_fire_s;
    logic            mispredict_s;
    logic [XLEN-1:0] next_pc_s;

    branch_cond_core #(.XLEN(XLEN)) u_cond (
        .a     (bus.in_a),
        .b     (bus.in_b),
        .op    (bus.in_op),
        .taken (cond_taken_s)
    );

    // Target generation; JALR adds to the register base and clears bit 0
    always_comb begin
        fallthru_s = bus.in_pc + XLEN'(ILEN_B);
        if (bus.in_op == JALR) begin
            sum_s    = bus.in_a + bus.in_imm;
            target_s = {sum_s[XLEN-1:1], 1'b0};
        end else begin
            sum_s    = bus.in_pc + bus.in_imm;
            target_s = sum_s;
        end
    end

    // Handshake and S2 result computation
    always_comb begin
        s2_move_s    = !s2_valid_r || bus.out_ready;
        in_ready_s   = !flush && (!s1_valid_r || s2_move_s);
        out_valid_s  = s2_valid_r && !flush;
        out_fire_s   = out_valid_s && bus.out_ready;
        mispredict_s = (s1_r.taken != s1_r.pred_taken) ||
                       (s1_r.taken && (s1_r.target != s1_r.pred_target));
        if (s1_r.taken) begin
            next_pc_s = s1_r.target;
        end else begin
            next_pc_s = s1_r.fallthru;
        end
    end

    // Pipeline registers; a stalled stage keeps its contents untouched
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_r       <= 1'b0;
            s1_r             <= '0;
            s2_valid_r       <= 1'b0;
            out_taken_r      <= 1'b0;
            out_mispredict_r <= 1'b0;
            out_target_r     <= '0;
            out_next_pc_r    <= '0;
        end else if (flush) begin
            s1_valid_r <= 1'b0;
            s2_valid_r <= 1'b0;
        end else begin
            if (s2_move_s) begin
                s2_valid_r <= s1_valid_r;
                if (s1_valid_r) begin
                    out_taken_r      <= s1_r.taken;
                    out_target_r     <= s1_r.target;
                    out_next_pc_r    <= next_pc_s;
                    out_mispredict_r <= mispredict_s;
                end
            end
            if (in_ready_s) begin
                s1_valid_r <= bus.in_valid;
                if (bus.in_valid) begin
                    s1_r.taken       <= cond_taken_s;
                    s1_r.target      <= target_s;
                    s1_r.fallthru    <= fallthru_s;
                    s1_r.pred_taken  <= bus.in_pred_taken;
                    s1_r.pred_target <= bus.in_pred_target;
                end
            end
        end
    end

    assign bus.in_ready       = in_ready_s;
    assign bus.out_valid      = out_valid_s;
    assign bus.out_taken      = out_taken_r;
    assign bus.out_target     = out_target_r;
    assign bus.out_next_pc    = out_next_pc_r;
    assign bus.out_mispredict = out_mispredict_r;

`ifdef BRANCH_STATS_EN
    logic [31:0] stat_branches_r;
    logic [31:0] stat_mispred_r;

    // Counters advance only on real output transfers, so flushed entries never count
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_branches_r <= 32'd0;
            stat_mispred_r  <= 32'd0;
        end else if (out_fire_s) begin
            stat_branches_r <= stat_branches_r + 32'd1;
            if (out_mispredict_r) begin
                stat_mispred_r <= stat_mispred_r + 32'd1;
            end
        end
    end

    assign stat_branches = stat_branches_r;
    assign stat_mispred  = stat_mispred_r;
`else
    logic unused_fire_s;
    assign unused_fire_s = out_fire_s;
`endif

endmodule
